full_32bit_adder: RTL and testbench
===================================

Name: full_32bit_adder

Overview:
- 32-bit ripple-carry adder computing {ca, sum} = a + b + cin.
- A chain of 32 one-bit full adders forms the combinational sum.
- Result is captured in output registers on each rising clock edge, giving a timing-clean arithmetic primitive for datapath use.
- Internal carry chain is pure ripple (LSB to MSB); no lookahead.

Parameters:
- WIDTH, 32, operand/sum width in bits. Only 32 is required to be supported and verified.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- a  input  WIDTH  operand A, unsigned.
- b  input  WIDTH  operand B, unsigned.
- cin  input  1  carry-in, added at bit 0.
- sum  output  WIDTH  registered sum bits [WIDTH-1:0] of a+b+cin.
- ca  output  1  registered carry-out, bit WIDTH of a+b+cin.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Combinational core:
  - c[0] = cin.
  - For i = 0..WIDTH-1: s[i] = a[i] ^ b[i] ^ c[i]; c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i])).
  - Carry-out is c[WIDTH].
- Registers: on each rising clk edge with rst_n high, sum <= s and ca <= c[WIDTH].
- Latency: exactly 1 cycle. Inputs applied before edge N appear on sum/ca after edge N.
- Throughput: one new operation per cycle. No handshake and no enable; outputs update every cycle.
- Reset:
  - rst_n low immediately forces sum = 0 and ca = 0, independent of clk.
  - Outputs hold 0 while rst_n is low.
  - The first capture happens on the first rising edge after rst_n deasserts.
  - Asserting reset mid-operation discards any in-flight result.
- Arithmetic:
  - Unsigned, modulo 2^WIDTH on sum.
  - ca = 1 exactly when a + b + cin >= 2^WIDTH.
  - Maximum case: a = b = all-ones, cin = 1 gives sum = all-ones, ca = 1.
- X handling: an X or Z on any input may propagate to the outputs. No masking is required.
- No internal state other than the WIDTH+1 output flops.

Decomposition:
- Shared package: constant ADDER_WIDTH = 32 and a typedef for the WIDTH-bit operand word.
- One natural sub-module, full_adder_1bit (ports a, b, cin, s, cout), instantiated WIDTH times via generate to form the ripple chain.
- Top level holds the carry wire vector and the output registers only.

Test Plan:
- Reset: hold rst_n low with a = 5, b = 7, cin = 1 -> sum = 0, ca = 0 regardless of clk. Release rst_n -> after the next edge sum = 13, ca = 0.
- Basic values: a = 0, b = 0, cin = 0 -> sum = 0, ca = 0. Then a = 1, b = 0, cin = 0 -> sum = 1, ca = 0. Then a = 1, b = 2, cin = 1 -> sum = 4, ca = 0. Each result appears one cycle after its inputs.
- Full ripple: a = 0xFFFFFFFF, b = 0x00000000, cin = 1 -> sum = 0x00000000, ca = 1. Carry propagates through all 32 bits.
- Maximum: a = 0xFFFFFFFF, b = 0xFFFFFFFF, cin = 1 -> sum = 0xFFFFFFFF, ca = 1. With cin = 0 -> sum = 0xFFFFFFFE, ca = 1.
- Back-to-back pipelining: change the inputs on every cycle (e.g. 0x80000000+0x80000000+0, then 0x7FFFFFFF+1+0) -> outputs (0, ca = 1) then (0x80000000, ca = 0) on consecutive cycles, each lagging its inputs by 1.
- Async reset mid-stream: assert rst_n low between clock edges while outputs are nonzero -> sum and ca drop to 0 without waiting for an edge. Then random-compare 1000 vectors against a + b + cin once reset is released.

Source files
------------

// File: rtl/full_32bit_adder_pkg.sv
// Shared constants and types for the registered ripple-carry adder.
package full_32bit_adder_pkg;

    localparam int unsigned ADDER_WIDTH = 32;

    typedef logic [ADDER_WIDTH-1:0] word_t;

endpackage : full_32bit_adder_pkg

// File: rtl/full_32bit_adder_if.sv
// Operand/result bundle for full_32bit_adder; clock and reset stay outside.
interface full_32bit_adder_if
    import full_32bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             ca;

    modport master (
        output a,
        output b,
        output cin,
        input  sum,
        input  ca
    );

    modport slave (
        input  a,
        input  b,
        input  cin,
        output sum,
        output ca
    );

endinterface : full_32bit_adder_if

// File: rtl/full_adder_1bit.sv
// One ripple stage: sum and carry-out of a + b + cin.
module full_adder_1bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule : full_adder_1bit

// File: rtl/full_32bit_adder.sv
// Ripple-carry adder with registered {ca, sum}; one-cycle latency, async active-low reset.
module full_32bit_adder
    import full_32bit_adder_pkg::*;
#(
    parameter int unsigned WIDTH = ADDER_WIDTH
) (
    input  logic               clk,
    input  logic               rst_n,
    full_32bit_adder_if.slave  bus
);

    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic [WIDTH-1:0] sum_q;
    logic             ca_d;
    logic             ca_q;

    assign carry[0] = bus.cin;

    // Carry ripples strictly LSB to MSB through WIDTH stages.
    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        full_adder_1bit u_fa (
            .a    (bus.a[i]),
            .b    (bus.b[i]),
            .cin  (carry[i]),
            .s    (sum_d[i]),
            .cout (carry[i+1])
        );
    end

    assign ca_d = carry[WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= '0;
            ca_q  <= 1'b0;
        end else begin
            sum_q <= sum_d;
            ca_q  <= ca_d;
        end
    end

    assign bus.sum = sum_q;
    assign bus.ca  = ca_q;

endmodule : full_32bit_adder

// File: tb/tb_full_32bit_adder.sv
// Directed and random checks of the registered 32-bit adder against hand-computed results.
module tb_full_32bit_adder;
    import full_32bit_adder_pkg::*;

    localparam int unsigned W = ADDER_WIDTH;

    logic clk;
    logic rst_n;

    int unsigned n_checks;
    int unsigned n_errors;
    logic [W:0]  last_exp;

    full_32bit_adder_if #(.WIDTH(W)) bus ();

    full_32bit_adder #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got {ca,sum}=%h, expected %h", tag, got, exp);
        end
    endtask

    // Drive between edges, confirm the old result is still held, then check after the edge.
    task automatic apply(input string tag, input word_t a, input word_t b,
                         input logic cin, input logic [W:0] exp);
        @(negedge clk);
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        #1;
        check({tag, " hold"}, {bus.ca, bus.sum}, last_exp);
        @(posedge clk);
        #1;
        check(tag, {bus.ca, bus.sum}, exp);
        last_exp = exp;
    endtask

    initial begin
        word_t       ra;
        word_t       rb;
        logic        rc;
        logic [W:0]  rexp;

        n_checks = 0;
        n_errors = 0;
        rst_n    = 1'b0;
        bus.a    = 32'd5;
        bus.b    = 32'd7;
        bus.cin  = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("reset hold after edge", {bus.ca, bus.sum}, '0);
        @(negedge clk);
        check("reset hold mid-cycle", {bus.ca, bus.sum}, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first capture", {bus.ca, bus.sum}, 33'd13);
        last_exp = 33'd13;

        apply("zero",     32'd0, 32'd0, 1'b0, 33'd0);
        apply("one",      32'd1, 32'd0, 1'b0, 33'd1);
        apply("1+2+1",    32'd1, 32'd2, 1'b1, 33'd4);
        apply("ripple",   32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 33'h1_0000_0000);
        apply("max cin1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFF);
        apply("max cin0", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33'h1_FFFF_FFFE);
        apply("msb+msb",  32'h8000_0000, 32'h8000_0000, 1'b0, 33'h1_0000_0000);
        apply("7fff+1",   32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 33'h0_8000_0000);
        apply("alt bits", 32'hAAAA_AAAA, 32'h5555_5555, 1'b1, 33'h1_0000_0000);
        apply("alt nocy", 32'hAAAA_AAAA, 32'h5555_5555, 1'b0, 33'h0_FFFF_FFFF);
        apply("mid",      32'h1234_5678, 32'h8765_4321, 1'b0, 33'h0_9999_9999);

        // Reset asserted between edges must clear outputs without a clock edge.
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset", {bus.ca, bus.sum}, '0);
        @(posedge clk);
        #1;
        check("reset over edge", {bus.ca, bus.sum}, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post-reset capture", {bus.ca, bus.sum}, 33'h0_9999_9999);
        last_exp = 33'h0_9999_9999;

        for (int i = 0; i < 1000; i++) begin
            ra   = $urandom;
            rb   = $urandom;
            rc   = 1'($urandom_range(0, 1));
            rexp = {1'b0, ra} + {1'b0, rb} + {{W{1'b0}}, rc};
            apply("random", ra, rb, rc, rexp);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_full_32bit_adder
